// File: rtl/adc_burst_sched_pkg.sv
// Shared types and constants for the ADC burst scheduler.
package adc_burst_sched_pkg;

  localparam int unsigned SAMPLE_CNT_W = 64;
  localparam int unsigned LEN_W        = 32;

  localparam logic [6:0] TAG_SOB  = 7'h01;
  localparam logic [6:0] TAG_NONE = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM
  } state_e;

  function automatic logic [6:0] tag_code(input logic sob);
    return sob ? TAG_SOB : TAG_NONE;
  endfunction

endpackage

// File: rtl/adc_burst_sched_if.sv
// Tagged ADC stream handshake: master drives beat fields, slave drives ready.
interface adc_burst_sched_if #(
  parameter int unsigned DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              tag_valid;
  logic [6:0]        tag_type;
  logic              last;

  modport master (output valid, data, tag_valid, tag_type, last, input ready);
  modport slave  (input valid, data, tag_valid, tag_type, last, output ready);
endinterface

// File: rtl/adc_burst_sched_skid_buf.sv
// Two-entry skid buffer with registered outputs; full throughput, s_ready comes straight from a flop.
module rwt_axis_skid_buf #(
  parameter int unsigned W = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         sk_valid_q, sk_valid_d;
  logic [W-1:0] sk_data_q, sk_data_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    if (!out_valid_q || m_ready) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = sk_data_q;
        sk_valid_d  = 1'b0;
      end else begin
        out_valid_d = s_valid;
        if (s_valid) out_data_d = s_data;
      end
    end else if (s_valid && !sk_valid_q) begin
      // Output stalled: park the beat accepted this cycle in the skid slot.
      sk_valid_d = 1'b1;
      sk_data_d  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
    end
  end

  assign s_ready = !sk_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/adc_burst_sched.sv
// Timed RX burst scheduler: discards ADC beats until a commanded sample count, then forwards a tagged burst.
// Optional saturating statistics counters when ADC_BURST_SCHED_STATS_EN is defined.
module adc_burst_sched
  import adc_burst_sched_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LATE_POLICY = 0
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [SAMPLE_CNT_W-1:0] cmd_start,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    abort,
  adc_burst_sched_if.slave        s_adc,
  adc_burst_sched_if.master       m_adc,
  output logic [SAMPLE_CNT_W-1:0] sample_count,
  output logic                    busy,
  output logic                    late_err,
  output logic                    len_err
`ifdef ADC_BURST_SCHED_STATS_EN
  ,
  output logic [31:0]             burst_cnt,
  output logic [15:0]             abort_cnt,
  output logic [15:0]             late_cnt
`endif
);

  localparam int unsigned SKID_W = DATA_W + 9;

  state_e                  state_q, state_d;
  logic [SAMPLE_CNT_W-1:0] start_q, start_d;
  logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        beat_q, beat_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    late_err_q, late_err_d;
  logic                    len_err_q, len_err_d;
  logic                    abort_pend_q, abort_pend_d;

  logic              s_rdy, acc, skid_s_ready;
  logic              fwd, fwd_sob, fwd_last, natural_last, abort_taken;
  logic [LEN_W-1:0]  beat_n;
  logic [SKID_W-1:0] skid_in, skid_out;

  always_comb begin
    unique case (state_q)
      STREAM:  s_rdy = skid_s_ready;
      // The start beat is forwarded straight from WAIT, so hold it off while the skid still drains the previous burst.
      WAIT:    s_rdy = (cnt_q == start_q) ? skid_s_ready : 1'b1;
      default: s_rdy = 1'b1;
    endcase
    acc    = s_adc.valid & s_rdy;
    beat_n = beat_q + 32'd1;

    state_d      = state_q;
    start_d      = start_q;
    len_d        = len_q;
    beat_d       = beat_q;
    abort_pend_d = abort_pend_q;
    late_err_d   = 1'b0;
    len_err_d    = 1'b0;
    fwd          = 1'b0;
    fwd_sob      = 1'b0;
    fwd_last     = 1'b0;
    natural_last = 1'b0;
    abort_taken  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            start_d      = cmd_start;
            len_d        = cmd_len;
            beat_d       = '0;
            abort_pend_d = 1'b0;
            state_d      = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          abort_taken = 1'b1;
          state_d     = IDLE;
        end else if (acc) begin
          if (cnt_q == start_q) begin
            fwd     = 1'b1;
            fwd_sob = 1'b1;
            beat_d  = 32'd1;
            if (len_q == 32'd1) begin
              fwd_last     = 1'b1;
              natural_last = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = STREAM;
            end
          end else if (cnt_q > start_q) begin
            late_err_d = 1'b1;
            state_d    = (LATE_POLICY != 0) ? STREAM : IDLE;
          end
        end
      end
      STREAM: begin
        abort_taken = abort;
        if (acc) begin
          fwd          = 1'b1;
          fwd_sob      = (beat_q == '0);
          natural_last = (beat_n == len_q);
          fwd_last     = natural_last | abort_pend_q;
          if (fwd_last) begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
          end else begin
            beat_d       = beat_n;
            abort_pend_d = abort;
          end
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    cnt_d       = cnt_q + {{(SAMPLE_CNT_W-1){1'b0}}, acc};
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= IDLE;
      start_q      <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      cmd_ready_q  <= 1'b0;
      late_err_q   <= 1'b0;
      len_err_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      cmd_ready_q  <= cmd_ready_d;
      late_err_q   <= late_err_d;
      len_err_q    <= len_err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign skid_in = {s_adc.data, fwd_sob, tag_code(fwd_sob), fwd_last};

  rwt_axis_skid_buf #(.W(SKID_W)) u_skid (
    .clk     (user_clk),
    .rst     (user_rst),
    .s_valid (fwd),
    .s_ready (skid_s_ready),
    .s_data  (skid_in),
    .m_valid (m_adc.valid),
    .m_ready (m_adc.ready),
    .m_data  (skid_out)
  );

  assign m_adc.data      = skid_out[SKID_W-1:9];
  assign m_adc.tag_valid = skid_out[8];
  assign m_adc.tag_type  = skid_out[7:1];
  assign m_adc.last      = skid_out[0];
  assign s_adc.ready     = s_rdy;

  assign cmd_ready    = cmd_ready_q;
  assign sample_count = cnt_q;
  assign busy         = (state_q != IDLE);
  assign late_err     = late_err_q;
  assign len_err      = len_err_q;

  logic unused_in;
  assign unused_in = ^{s_adc.tag_valid, s_adc.tag_type, s_adc.last};

`ifdef ADC_BURST_SCHED_STATS_EN
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;
  logic [15:0] late_cnt_q, late_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    abort_cnt_d = abort_cnt_q;
    late_cnt_d  = late_cnt_q;
    if (natural_last && (burst_cnt_q != '1)) burst_cnt_d = burst_cnt_q + 32'd1;
    if (abort_taken && (abort_cnt_q != '1)) abort_cnt_d = abort_cnt_q + 16'd1;
    if (late_err_d && (late_cnt_q != '1)) late_cnt_d = late_cnt_q + 16'd1;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      burst_cnt_q <= '0;
      abort_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign abort_cnt = abort_cnt_q;
  assign late_cnt  = late_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = abort_taken;
`endif

endmodule

// File: tb/tb_adc_burst_sched.sv
// Directed self-checking bench for adc_burst_sched; dut0 uses LATE_POLICY=0, dut1 LATE_POLICY=1 on shared stimulus.
module tb_adc_burst_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, abort, s_valid, m_ready, exp_rdy;
  logic [63:0] cmd_start, s_data, mcnt;
  logic [31:0] cmd_len;
  int          errors = 0;
  int          checks = 0;

  logic        cmd_ready0, cmd_ready1, busy0, busy1;
  logic        late_err0, late_err1, len_err0, len_err1;
  logic [63:0] sample_count0, sample_count1;
`ifdef ADC_BURST_SCHED_STATS_EN
  logic [31:0] burst_cnt0, burst_cnt1;
  logic [15:0] abort_cnt0, abort_cnt1, late_cnt0, late_cnt1;
`endif

  adc_burst_sched_if #(.DATA_W(64)) s0 ();
  adc_burst_sched_if #(.DATA_W(64)) m0 ();
  adc_burst_sched_if #(.DATA_W(64)) s1 ();
  adc_burst_sched_if #(.DATA_W(64)) m1 ();

  assign s0.valid = s_valid;      assign s1.valid = s_valid;
  assign s0.data = s_data;        assign s1.data = s_data;
  assign s0.tag_valid = 1'b0;     assign s1.tag_valid = 1'b0;
  assign s0.tag_type = 7'h00;     assign s1.tag_type = 7'h00;
  assign s0.last = 1'b0;          assign s1.last = 1'b0;
  assign m0.ready = m_ready;      assign m1.ready = m_ready;

  adc_burst_sched #(.DATA_W(64), .LATE_POLICY(0)) dut0 (
    .user_clk(clk), .user_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .abort(abort), .s_adc(s0), .m_adc(m0),
    .sample_count(sample_count0), .busy(busy0), .late_err(late_err0), .len_err(len_err0)
`ifdef ADC_BURST_SCHED_STATS_EN
    , .burst_cnt(burst_cnt0), .abort_cnt(abort_cnt0), .late_cnt(late_cnt0)
`endif
  );

  adc_burst_sched #(.DATA_W(64), .LATE_POLICY(1)) dut1 (
    .user_clk(clk), .user_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .abort(abort), .s_adc(s1), .m_adc(m1),
    .sample_count(sample_count1), .busy(busy1), .late_err(late_err1), .len_err(len_err1)
`ifdef ADC_BURST_SCHED_STATS_EN
    , .burst_cnt(burst_cnt1), .abort_cnt(abort_cnt1), .late_cnt(late_cnt1)
`endif
  );

  function automatic logic [63:0] d_of(input logic [63:0] n);
    return {16'hDA7A, n[47:0]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input bit sel, input string tag, input logic [63:0] n,
                          input logic sob, input logic last);
    logic v, tv, l;
    logic [63:0] d;
    logic [6:0] tt;
    v  = sel ? m1.valid : m0.valid;
    d  = sel ? m1.data : m0.data;
    tv = sel ? m1.tag_valid : m0.tag_valid;
    tt = sel ? m1.tag_type : m0.tag_type;
    l  = sel ? m1.last : m0.last;
    chk1({tag, ".valid"}, v, 1'b1);
    chk64({tag, ".data"}, d, d_of(n));
    chk1({tag, ".tag_valid"}, tv, sob);
    chk64({tag, ".tag_type"}, 64'(tt), sob ? 64'd1 : 64'd0);
    chk1({tag, ".last"}, l, last);
  endtask

  // Model beat counter: a presented beat carries count mcnt; it advances when the bench expects acceptance.
  task automatic step();
    @(posedge clk);
    if (rst) mcnt = '0;
    else if (s_valid && exp_rdy) mcnt = mcnt + 64'd1;
    #1;
    s_data = d_of(mcnt);
  endtask

  task automatic wait_cnt(input logic [63:0] target);
    while (mcnt < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; cmd_valid = 1'b0; cmd_start = '0;
    cmd_len = '0; abort = 1'b0; exp_rdy = 1'b1; mcnt = '0; s_data = d_of(64'd0);
    step(); step();
    chk1("rst.m_valid", m0.valid, 1'b0);
    chk64("rst.m_data", m0.data, 64'd0);
    chk1("rst.s_ready", s0.ready, 1'b1);
    chk1("rst.cmd_ready", cmd_ready0, 1'b0);
    chk1("rst.busy", busy0, 1'b0);
    chk64("rst.sample_count", sample_count0, 64'd0);
    rst = 1'b0;
    step();
    chk1("post_rst.cmd_ready", cmd_ready0, 1'b1);

    // Test 1: start=100 len=4, continuous input
    s_valid = 1'b1; cmd_valid = 1'b1; cmd_start = 64'd100; cmd_len = 32'd4;
    step(); cmd_valid = 1'b0;
    chk1("t1.busy", busy0, 1'b1);
    chk1("t1.cmd_ready", cmd_ready0, 1'b0);
    wait_cnt(64'd100);
    chk1("t1.wait_quiet", m0.valid, 1'b0);
    step(); chk_beat(0, "t1.b1", 64'd100, 1'b1, 1'b0);
    step(); chk_beat(0, "t1.b2", 64'd101, 1'b0, 1'b0);
    step(); chk_beat(0, "t1.b3", 64'd102, 1'b0, 1'b0);
    step(); chk_beat(0, "t1.b4", 64'd103, 1'b0, 1'b1);
    chk1("t1.busy_end", busy0, 1'b0);
    step();
    chk1("t1.idle_quiet", m0.valid, 1'b0);
    chk64("t1.sample_count", sample_count0, 64'd105);
`ifdef ADC_BURST_SCHED_STATS_EN
    chk64("t1.burst_cnt", 64'(burst_cnt0), 64'd1);
`endif

    // Test 3: len=0 rejected
    cmd_valid = 1'b1; cmd_start = 64'd5; cmd_len = 32'd0;
    step(); cmd_valid = 1'b0;
    chk1("t3.len_err", len_err0, 1'b1);
    chk1("t3.cmd_ready", cmd_ready0, 1'b1);
    chk1("t3.busy", busy0, 1'b0);
    step();
    chk1("t3.len_err_pulse", len_err0, 1'b0);

    // Test 2: start=10 issued at cnt 107
    cmd_valid = 1'b1; cmd_start = 64'd10; cmd_len = 32'd4;
    step(); cmd_valid = 1'b0;
    chk1("t2.busy", busy0, 1'b1);
    step();
    chk1("t2.p0.late_err", late_err0, 1'b1);
    chk1("t2.p0.busy", busy0, 1'b0);
    chk1("t2.p0.quiet", m0.valid, 1'b0);
    chk1("t2.p1.late_err", late_err1, 1'b1);
    chk1("t2.p1.busy", busy1, 1'b1);
    step();
    chk1("t2.p0.late_pulse", late_err0, 1'b0);
    chk1("t2.p0.quiet2", m0.valid, 1'b0);
    chk_beat(1, "t2.p1.b1", 64'd109, 1'b1, 1'b0);
    step(); chk_beat(1, "t2.p1.b2", 64'd110, 1'b0, 1'b0);
    step(); chk_beat(1, "t2.p1.b3", 64'd111, 1'b0, 1'b0);
    step(); chk_beat(1, "t2.p1.b4", 64'd112, 1'b0, 1'b1);
    chk1("t2.p1.busy_end", busy1, 1'b0);
    chk1("t2.p0.quiet3", m0.valid, 1'b0);
`ifdef ADC_BURST_SCHED_STATS_EN
    chk64("t2.late_cnt", 64'(late_cnt0), 64'd1);
`endif
    step();
    chk1("t2.p1.idle_quiet", m1.valid, 1'b0);

    // Test 4: start=120 len=8 with a 5-cycle output stall
    cmd_valid = 1'b1; cmd_start = 64'd120; cmd_len = 32'd8;
    step(); cmd_valid = 1'b0;
    wait_cnt(64'd120);
    step(); chk_beat(0, "t4.b1", 64'd120, 1'b1, 1'b0);
    step(); chk_beat(0, "t4.b2", 64'd121, 1'b0, 1'b0);
    m_ready = 1'b0;
    step();
    chk_beat(0, "t4.hold0", 64'd121, 1'b0, 1'b0);
    chk1("t4.s_ready_low0", s0.ready, 1'b0);
    exp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_beat(0, "t4.hold", 64'd121, 1'b0, 1'b0);
      chk1("t4.s_ready_low", s0.ready, 1'b0);
      chk64("t4.cnt_frozen", sample_count0, 64'd123);
    end
    m_ready = 1'b1;
    step();
    chk_beat(0, "t4.b3", 64'd122, 1'b0, 1'b0);
    chk1("t4.s_ready_back", s0.ready, 1'b1);
    exp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_beat(0, "t4.tail", 64'd123 + 64'(i), 1'b0, i == 4);
    end
    chk1("t4.busy_end", busy0, 1'b0);
    chk64("t4.sample_count", sample_count0, 64'd128);

    // Test 5a: abort with beat 3 of len=10 -> beat 4 is last
    cmd_valid = 1'b1; cmd_start = 64'd131; cmd_len = 32'd10;
    step(); cmd_valid = 1'b0;
    wait_cnt(64'd131);
    step(); chk_beat(0, "t5a.b1", 64'd131, 1'b1, 1'b0);
    step(); chk_beat(0, "t5a.b2", 64'd132, 1'b0, 1'b0);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_beat(0, "t5a.b3", 64'd133, 1'b0, 1'b0);
    chk1("t5a.busy_mid", busy0, 1'b1);
    step(); chk_beat(0, "t5a.b4", 64'd134, 1'b0, 1'b1);
    chk1("t5a.busy_end", busy0, 1'b0);
    step();
    chk1("t5a.quiet", m0.valid, 1'b0);
`ifdef ADC_BURST_SCHED_STATS_EN
    chk64("t5a.abort_cnt", 64'(abort_cnt0), 64'd1);
`endif

    // Test 5b: abort coincident with the natural last beat
    cmd_valid = 1'b1; cmd_start = 64'd140; cmd_len = 32'd10;
    step(); cmd_valid = 1'b0;
    wait_cnt(64'd140);
    for (int i = 0; i < 9; i++) begin
      step();
      chk_beat(0, "t5b.b", 64'd140 + 64'(i), i == 0, 1'b0);
    end
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_beat(0, "t5b.b10", 64'd149, 1'b0, 1'b1);
    chk1("t5b.busy_end", busy0, 1'b0);
    step();
    chk1("t5b.no_extra", m0.valid, 1'b0);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk1("t5c.idle_abort_busy", busy0, 1'b0);
    chk1("t5c.idle_abort_cmd_ready", cmd_ready0, 1'b1);

    // Test 6: reset in STREAM
    cmd_valid = 1'b1; cmd_start = 64'd155; cmd_len = 32'd5;
    step(); cmd_valid = 1'b0;
    wait_cnt(64'd155);
    step(); chk_beat(0, "t6.b1", 64'd155, 1'b1, 1'b0);
    step(); chk_beat(0, "t6.b2", 64'd156, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk1("t6.m_valid", m0.valid, 1'b0);
    chk64("t6.m_data", m0.data, 64'd0);
    chk1("t6.tag_valid", m0.tag_valid, 1'b0);
    chk1("t6.last", m0.last, 1'b0);
    chk1("t6.busy", busy0, 1'b0);
    chk1("t6.cmd_ready", cmd_ready0, 1'b0);
    chk1("t6.s_ready", s0.ready, 1'b1);
    chk64("t6.sample_count", sample_count0, 64'd0);
`ifdef ADC_BURST_SCHED_STATS_EN
    chk64("t6.burst_cnt", 64'(burst_cnt0), 64'd0);
    chk64("t6.late_cnt", 64'(late_cnt0), 64'd0);
`endif
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk1("t6.cmd_ready_after", cmd_ready0, 1'b1);
    chk1("t6.no_tail_beat", m0.valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
